apb_to_axi4lite_bridge: RTL

//  - APB4 completer (slave) to AXI4-Lite manager (master) bridge.
//  - Each APB transfer becomes exactly one AXI4-Lite write or read. pready is held low until the AXI response returns.
//  - Lets an APB-side host reach AXI4-Lite peripherals. It is the opposite direction of our AXI-to-APB path.
//  - Its manager port connects to the axiMaster modport of axi4_Lite.

---
 rtl/apb_to_axi4lite_bridge_pkg.sv | 23 ++
 rtl/apb_to_axi4lite_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_axi4lite_bridge_pkg.sv
// Shared types and AXI response encodings for the APB4 to AXI4-Lite bridge.
package apb_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } bridge_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Only SLVERR and DECERR are reported to the APB side as an error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/apb_to_axi4lite_bridge.sv
// APB4 completer that turns each APB transfer into exactly one AXI4-Lite
// write or read, holding pready low until the AXI response has returned.
module apb_to_axi4lite_bridge
   import apb_axi_bridge_pkg::*;
#(
   parameter int ADDRWIDTH = 32,
   parameter int DATAWIDTH = 32
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   psel,
   input  logic                   penable,
   input  logic                   pwrite,
   input  logic [ADDRWIDTH-1:0]   paddr,
   input  logic [2:0]             pprot,
   input  logic [DATAWIDTH-1:0]   pwdata,
   input  logic [DATAWIDTH/8-1:0] pstrb,
   output logic                   pready,
   output logic [DATAWIDTH-1:0]   prdata,
   output logic                   pslverr,
   output logic [ADDRWIDTH-1:0]   awaddrM,
   output logic [2:0]             awprotM,
   output logic                   awvalidM,
   input  logic                   awreadyM,
   output logic [DATAWIDTH-1:0]   wdataM,
   output logic [DATAWIDTH/8-1:0] wstrbM,
   output logic                   wvalidM,
   input  logic                   wreadyM,
   input  logic [1:0]             brespM,
   input  logic                   bvalidM,
   output logic                   breadyM,
   output logic [ADDRWIDTH-1:0]   araddrM,
   output logic [2:0]             arprotM,
   output logic                   arvalidM,
   input  logic                   arreadyM,
   input  logic [DATAWIDTH-1:0]   rdataM,
   input  logic [1:0]             rrespM,
   input  logic                   rvalidM,
   output logic                   rreadyM
);

   bridge_state_t          state_q, state_d;
   logic [ADDRWIDTH-1:0]   addr_q, addr_d;
   logic [2:0]             prot_q, prot_d;
   logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
   logic [DATAWIDTH/8-1:0] strb_q, strb_d;
   logic                   awvalid_q, awvalid_d;
   logic                   wvalid_q, wvalid_d;
   logic                   arvalid_q, arvalid_d;
   logic                   bready_q, bready_d;
   logic                   rready_q, rready_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;
   logic                   pready_q, pready_d;
   logic                   pslverr_q, pslverr_d;
   logic [DATAWIDTH-1:0]   prdata_q, prdata_d;

   logic aw_hs, w_hs;

   assign aw_hs = awvalid_q && awreadyM;
   assign w_hs  = wvalid_q && wreadyM;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      prot_d    = prot_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      bready_d  = bready_q;
      rready_d  = rready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      pready_d  = 1'b0;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;

      case (state_q)
         IDLE: begin
            // Only a setup phase starts work; access phases seen here are stale.
            if (psel && !penable) begin
               addr_d    = paddr;
               prot_d    = pprot;
               wdata_d   = pwdata;
               strb_d    = pstrb;
               prdata_d  = '0;
               pslverr_d = 1'b0;
               if (pwrite) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (bvalidM && bready_q) begin
               pslverr_d = resp_is_err(brespM);
               bready_d  = 1'b0;
               pready_d  = 1'b1;
               state_d   = DONE;
            end
         end
         RD_REQ: begin
            if (arvalid_q && arreadyM) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (rvalidM && rready_q) begin
               prdata_d  = rdataM;
               pslverr_d = resp_is_err(rrespM);
               rready_d  = 1'b0;
               pready_d  = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         prot_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         prot_q    <= prot_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         bready_q  <= bready_d;
         rready_q  <= rready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign pready   = pready_q;
   assign pslverr  = pslverr_q;
   assign prdata   = prdata_q;
   assign awaddrM  = addr_q;
   assign araddrM  = addr_q;
   assign awprotM  = prot_q;
   assign arprotM  = prot_q;
   assign wdataM   = wdata_q;
   assign wstrbM   = strb_q;
   assign awvalidM = awvalid_q;
   assign wvalidM  = wvalid_q;
   assign arvalidM = arvalid_q;
   assign breadyM  = bready_q;
   assign rreadyM  = rready_q;

endmodule
